// File: rtl/sbox_lane_pipe.sv
// sbox_lane_pipe: LANES independent AES S-box lanes behind a valid/ready
// elastic pipeline of PIPE (1 or 2) stages. Each word carries its own
// forward/inverse mode tag, so modes may be interleaved back-to-back.
// The last stage always registers the table output, so the lookup never
// drives a port combinationally.
module sbox_lane_pipe #(
    parameter int LANES  = 4,
    parameter int PIPE   = 1,
    parameter bit INV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               busy
);

    localparam int W = 8 * LANES;

    // Entry 0 sits in the most significant byte, so byte b lives at bit
    // offset 8*(255-b) = {~b, 3'b000}.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        if (inv) begin
            sub_byte = SBOX_INV[idx +: 8];
        end else begin
            sub_byte = SBOX_FWD[idx +: 8];
        end
    endfunction

    // With the inverse table disabled every word is forced to forward mode,
    // which also forces the travelling tag (and so out_inv) to 0.
    logic mode_in;
    assign mode_in = INV_EN ? in_inv : 1'b0;

    // Output stage state
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         out_inv_q,   out_inv_d;

    // Output stage can take a new word when empty or when its word leaves now
    logic out_free;
    assign out_free = !out_valid_q || out_ready;

    // Word feeding the table lookup (raw input for PIPE=1, stage 0 for PIPE=2)
    logic         src_valid;
    logic [W-1:0] src_data;
    logic         src_inv;
    logic         stage0_valid;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic         s0_valid_q, s0_valid_d;
            logic [W-1:0] s0_data_q,  s0_data_d;
            logic         s0_inv_q,   s0_inv_d;

            // Stage 0 loads when empty or draining into the output stage
            always_comb begin
                s0_valid_d = s0_valid_q;
                s0_data_d  = s0_data_q;
                s0_inv_d   = s0_inv_q;
                if (in_valid && (!s0_valid_q || out_free)) begin
                    s0_valid_d = 1'b1;
                    s0_data_d  = in_data;
                    s0_inv_d   = mode_in;
                end else if (out_free) begin
                    s0_valid_d = 1'b0;
                end
            end

            // Stage 0 registers, cleared by reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s0_valid_q <= 1'b0;
                    s0_data_q  <= '0;
                    s0_inv_q   <= 1'b0;
                end else begin
                    s0_valid_q <= s0_valid_d;
                    s0_data_q  <= s0_data_d;
                    s0_inv_q   <= s0_inv_d;
                end
            end

            assign src_valid    = s0_valid_q;
            assign src_data     = s0_data_q;
            assign src_inv      = s0_inv_q;
            assign stage0_valid = s0_valid_q;
            assign in_ready     = rst_n && (!s0_valid_q || out_free);
        end else begin : g_pipe1
            assign src_valid    = in_valid;
            assign src_data     = in_data;
            assign src_inv      = mode_in;
            assign stage0_valid = 1'b0;
            assign in_ready     = rst_n && out_free;
        end
    endgenerate

    // Per-lane lookups; lanes never interact
    logic [W-1:0] lut_data;
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lut_data[8*gi +: 8] = sub_byte(src_data[8*gi +: 8], src_inv);
        end
    endgenerate

    // Output stage: load the substituted word, or go empty once consumed
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_inv_d   = out_inv_q;
        if (src_valid && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = lut_data;
            out_inv_d   = src_inv;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_inv_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_inv_q   <= out_inv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_inv   = out_inv_q;
    assign busy      = out_valid_q || stage0_valid;

endmodule
